// File: rtl/eh2_btb_upd_pkg.sv
// Shared types for the BTB/BHT update writer: queue entry layout, head-slot FSM
// states and the index/tag geometry used by both the hash and the queue.
package eh2_btb_upd_pkg;

    localparam int BTB_ADDR_LO   = 3;
    localparam int BTB_ADDR_HI   = 10;
    localparam int BTB_BTAG_SIZE = 5;
    localparam int BHT_GHR_SIZE  = 8;

    localparam int IW = BTB_ADDR_HI - BTB_ADDR_LO + 1;
    localparam int TW = BTB_BTAG_SIZE;

    // One resolved-branch update, with both lookup hashes already applied.
    typedef struct packed {
        logic [IW-1:0] idx;
        logic          way;
        logic [TW-1:0] tag;
        logic [30:0]   tgt;
        logic          valid;
        logic [IW-1:0] bht_idx;
        logic [1:0]    ctr;
    } btb_upd_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PEND    = 2'd1,
        ST_STARVED = 2'd2
    } upd_state_e;

endpackage

// File: rtl/eh2_btb_upd_writer_if.sv
// Update-request channel (branch resolution -> writer) and BTB/BHT array write
// port (writer -> array arbiter).
interface eh2_btb_upd_req_if;
    import eh2_btb_upd_pkg::*;

    logic                    upd_valid;
    logic                    upd_ready;
    logic [30:0]             upd_pc;
    logic                    upd_way;
    logic                    upd_inval;
    logic [30:0]             upd_tgt;
    logic [BHT_GHR_SIZE-1:0] upd_ghr;
    logic [1:0]              upd_ctr;

    modport master (
        output upd_valid, upd_pc, upd_way, upd_inval, upd_tgt, upd_ghr, upd_ctr,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_pc, upd_way, upd_inval, upd_tgt, upd_ghr, upd_ctr,
        output upd_ready
    );
endinterface

interface eh2_btb_wr_if;
    import eh2_btb_upd_pkg::*;

    logic          wr_req;
    logic          wr_force;
    logic          wr_gnt;
    logic [IW-1:0] wr_btb_idx;
    logic          wr_btb_way;
    logic [TW-1:0] wr_btb_tag;
    logic [30:0]   wr_btb_tgt;
    logic          wr_btb_valid;
    logic [IW-1:0] wr_bht_idx;
    logic [1:0]    wr_bht_ctr;

    modport master (
        output wr_req, wr_force, wr_btb_idx, wr_btb_way, wr_btb_tag, wr_btb_tgt,
               wr_btb_valid, wr_bht_idx, wr_bht_ctr,
        input  wr_gnt
    );

    modport slave (
        input  wr_req, wr_force, wr_btb_idx, wr_btb_way, wr_btb_tag, wr_btb_tgt,
               wr_btb_valid, wr_bht_idx, wr_bht_ctr,
        output wr_gnt
    );
endinterface

// File: rtl/eh2_btb_upd_hash.sv
// Combinational BTB index/tag and GHR-hashed BHT index, identical to the fetch
// lookup hashes so an update lands in the slot that fetch will read.
module eh2_btb_upd_hash
    import eh2_btb_upd_pkg::*;
(
    input  logic [30:0]             pc,
    input  logic [BHT_GHR_SIZE-1:0] ghr,
    output logic [IW-1:0]           btb_idx,
    output logic [TW-1:0]           btb_tag,
    output logic [IW-1:0]           bht_idx
);

    localparam int HI = BTB_ADDR_HI;
    localparam int LO = BTB_ADDR_LO;

    // pc carries PC[31:1]; rebuild the byte address so slices use PC bit numbers.
    logic [31:0] pc_full;
    logic        unused_pc;

    assign pc_full   = {pc, 1'b0};
    assign unused_pc = ^pc_full;

    assign btb_idx = pc_full[HI:LO]
                   ^ pc_full[HI+IW:LO+IW]
                   ^ pc_full[HI+2*IW:LO+2*IW];

    assign btb_tag = pc_full[HI+TW:HI+1]
                   ^ pc_full[HI+2*TW:HI+TW+1]
                   ^ pc_full[HI+3*TW:HI+2*TW+1];

    assign bht_idx = btb_idx ^ ghr;

endmodule

// File: rtl/eh2_btb_upd_writer.sv
// Buffers resolved-branch BTB/BHT updates in a small coalescing queue and drains
// them to the shared array write port, escalating to wr_force when starved.
module eh2_btb_upd_writer
    import eh2_btb_upd_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    eh2_btb_upd_req_if.slave       upd,
    eh2_btb_wr_if.master           wr,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    btb_upd_entry_t q_mem [DEPTH];
    btb_upd_entry_t new_entry;
    btb_upd_entry_t head;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    upd_state_e    state;
    upd_state_e    state_nxt;

    logic [IW-1:0] new_idx;
    logic [TW-1:0] new_tag;
    logic [IW-1:0] new_bht_idx;

    logic req_int;
    logic ready_int;
    logic push;
    logic pop;
    logic coalesce;

    eh2_btb_upd_hash u_hash (
        .pc      (upd.upd_pc),
        .ghr     (upd.upd_ghr),
        .btb_idx (new_idx),
        .btb_tag (new_tag),
        .bht_idx (new_bht_idx)
    );

    always_comb begin
        new_entry         = '0;
        new_entry.idx     = new_idx;
        new_entry.way     = upd.upd_way;
        new_entry.tag     = new_tag;
        new_entry.tgt     = upd.upd_tgt;
        new_entry.valid   = ~upd.upd_inval;
        new_entry.bht_idx = new_bht_idx;
        new_entry.ctr     = upd.upd_ctr;
    end

    // Ready and request come from registered state only, so no upd_* -> wr_* path.
    assign ready_int = (count != CW'(DEPTH));
    assign req_int   = (state != ST_EMPTY);
    assign head      = q_mem[rd_ptr];
    assign tail_ptr  = wr_ptr - 1'b1;

    assign push = upd.upd_valid && ready_int && !flush;
    assign pop  = req_int && wr.wr_gnt;

    // A lone entry under grant is already being written, so it cannot absorb a push.
    assign coalesce = push && (count != '0)
                   && (q_mem[tail_ptr].idx == new_idx)
                   && (q_mem[tail_ptr].way == upd.upd_way)
                   && !((count == CW'(1)) && pop);

    // NOTE: every signal written in always_comb gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_nxt = count + CW'(push && !coalesce) - CW'(pop);
        if (flush) count_nxt = '0;

        starve_nxt = starve_cnt;
        if (flush || pop || !req_int) begin
            starve_nxt = '0;
        end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_nxt = starve_cnt + 1'b1;
        end

        state_nxt = state;
        unique case (state)
            ST_EMPTY: begin
                if (push) state_nxt = ST_PEND;
            end
            ST_PEND, ST_STARVED: begin
                if (pop) begin
                    state_nxt = (count_nxt != '0) ? ST_PEND : ST_EMPTY;
                end else if (starve_nxt == SW'(STARVE_LIMIT)) begin
                    state_nxt = ST_STARVED;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) state_nxt = ST_EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            // NOTE: the storage is reset because the write-port payload is read
            // straight from it and must be zero out of reset; it is only DEPTH words.
            for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            starve_cnt <= starve_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    if (coalesce) begin
                        q_mem[tail_ptr] <= new_entry;
                    end else begin
                        q_mem[wr_ptr] <= new_entry;
                        wr_ptr        <= wr_ptr + 1'b1;
                    end
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign upd.upd_ready   = ready_int;
    assign wr.wr_req       = req_int;
    assign wr.wr_force     = req_int && (starve_cnt == SW'(STARVE_LIMIT));
    assign wr.wr_btb_idx   = head.idx;
    assign wr.wr_btb_way   = head.way;
    assign wr.wr_btb_tag   = head.tag;
    assign wr.wr_btb_tgt   = head.tgt;
    assign wr.wr_btb_valid = head.valid;
    assign wr.wr_bht_idx   = head.bht_idx;
    assign wr.wr_bht_ctr   = head.ctr;
    assign q_count         = count;

endmodule

// File: tb/tb_eh2_btb_upd_writer.sv
// Directed and randomized bench for eh2_btb_upd_writer against a queue-based
// reference model that applies the update/coalesce/drain rules directly.
module tb_eh2_btb_upd_writer;

    localparam int DEPTH = 4;
    localparam int LIMIT = 15;

    typedef struct packed {
        logic [7:0]  idx;
        logic        way;
        logic [4:0]  tag;
        logic [30:0] tgt;
        logic        valid;
        logic [7:0]  bht;
        logic [1:0]  ctr;
    } m_entry_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] q_count;

    eh2_btb_upd_req_if u_upd ();
    eh2_btb_wr_if      u_wr ();

    eh2_btb_upd_writer #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk     (clk),
        .rst     (rst),
        .upd     (u_upd.slave),
        .wr      (u_wr.master),
        .flush   (flush),
        .q_count (q_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    m_entry_t exp_q[$];
    int       m_starve = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lookup hashes written from PC byte-address arithmetic.
    function automatic m_entry_t make_entry(input logic [30:0] pc, input logic way,
                                            input logic inval, input logic [30:0] tgt,
                                            input logic [7:0] ghr, input logic [1:0] ctr);
        m_entry_t    e;
        int unsigned a;
        a       = {pc, 1'b0};
        e.idx   = 8'((a >> 3) ^ (a >> 11) ^ (a >> 19));
        e.tag   = 5'((a >> 11) ^ (a >> 16) ^ (a >> 21));
        e.bht   = e.idx ^ ghr;
        e.way   = way;
        e.tgt   = tgt;
        e.valid = !inval;
        e.ctr   = ctr;
        return e;
    endfunction

    function automatic logic [55:0] dut_payload();
        return {u_wr.wr_btb_idx, u_wr.wr_btb_way, u_wr.wr_btb_tag, u_wr.wr_btb_tgt,
                u_wr.wr_btb_valid, u_wr.wr_bht_idx, u_wr.wr_bht_ctr};
    endfunction

    task automatic model_step(input logic v, input m_entry_t n, input logic fl, input logic gnt);
        int sz;
        bit pop_m;
        bit push_m;
        bit coal_m;
        sz     = exp_q.size();
        pop_m  = (sz > 0) && gnt;
        push_m = v && (sz < DEPTH) && !fl;
        coal_m = push_m && (sz > 0) && (exp_q[sz-1].idx == n.idx) &&
                 (exp_q[sz-1].way == n.way) && !(sz == 1 && pop_m);
        if (fl || pop_m || sz == 0) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (coal_m) exp_q[sz-1] = n;
            if (pop_m) void'(exp_q.pop_front());
            if (push_m && !coal_m) exp_q.push_back(n);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = exp_q.size();
        check("wr_req", 64'(u_wr.wr_req), 64'(sz != 0));
        check("upd_ready", 64'(u_upd.upd_ready), 64'(sz != DEPTH));
        check("q_count", 64'(q_count), 64'(sz));
        check("wr_force", 64'(u_wr.wr_force), 64'(sz != 0 && m_starve == LIMIT));
        if (sz != 0) check("payload", 64'(dut_payload()), 64'(exp_q[0]));
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model,
    // then compare at the next falling edge.
    task automatic drive_cycle(input logic v, input logic [30:0] pc, input logic way,
                               input logic inval, input logic [30:0] tgt,
                               input logic [7:0] ghr, input logic [1:0] ctr,
                               input logic fl, input logic gnt, input logic rs);
        u_upd.upd_valid = v;
        u_upd.upd_pc    = pc;
        u_upd.upd_way   = way;
        u_upd.upd_inval = inval;
        u_upd.upd_tgt   = tgt;
        u_upd.upd_ghr   = ghr;
        u_upd.upd_ctr   = ctr;
        flush           = fl;
        u_wr.wr_gnt     = gnt;
        rst             = rs;
        if (rs) begin
            exp_q.delete();
            m_starve = 0;
        end else begin
            model_step(v, make_entry(pc, way, inval, tgt, ghr, ctr), fl, gnt);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic gnt);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, gnt, 1'b0);
    endtask

    task automatic push_pc(input logic [30:0] pc, input logic [30:0] tgt, input logic gnt);
        drive_cycle(1'b1, pc, 1'b0, 1'b0, tgt, 8'h3C, 2'b10, 1'b0, gnt, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, 64'(u_wr.wr_req), 64'(0));
        check({tag, "_force"}, 64'(u_wr.wr_force), 64'(0));
        check({tag, "_ready"}, 64'(u_upd.upd_ready), 64'(1));
        check({tag, "_count"}, 64'(q_count), 64'(0));
        check({tag, "_payload"}, 64'(dut_payload()), 64'(0));
    endtask

    logic [30:0] pool_pc [6];
    int          first_force;

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        u_upd.upd_valid = 1'b0;
        u_upd.upd_pc    = '0;
        u_upd.upd_way   = 1'b0;
        u_upd.upd_inval = 1'b0;
        u_upd.upd_tgt   = '0;
        u_upd.upd_ghr   = '0;
        u_upd.upd_ctr   = '0;
        u_wr.wr_gnt     = 1'b0;
        @(negedge clk);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        check_reset_state("reset");

        // Single update with grant tied high.
        drive_cycle(1'b1, 31'h404, 1'b0, 1'b0, 31'h1234, 8'hA5, 2'b11, 1'b0, 1'b1, 1'b0);
        check("t1_req", 64'(u_wr.wr_req), 64'(1));
        check("t1_idx", 64'(u_wr.wr_btb_idx), 64'h00);
        check("t1_tag", 64'(u_wr.wr_btb_tag), 64'h01);
        check("t1_bht", 64'(u_wr.wr_bht_idx), 64'hA5);
        idle(1'b1);
        check("t1_drained", 64'(q_count), 64'(0));

        // Invalidate.
        drive_cycle(1'b1, 31'h8, 1'b1, 1'b1, 31'h55, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0);
        check("t2_idx", 64'(u_wr.wr_btb_idx), 64'h02);
        check("t2_tag", 64'(u_wr.wr_btb_tag), 64'h00);
        check("t2_valid", 64'(u_wr.wr_btb_valid), 64'(0));
        idle(1'b1);

        // Fill to DEPTH, overflow attempt, ordered drain.
        for (int i = 1; i <= 4; i++) push_pc(31'(i << 2), 31'(i * 16), 1'b0);
        check("t3_full_count", 64'(q_count), 64'(4));
        check("t3_full_ready", 64'(u_upd.upd_ready), 64'(0));
        push_pc(31'(5 << 2), 31'h99, 1'b0);
        check("t3_overflow_count", 64'(q_count), 64'(4));
        for (int i = 1; i <= 4; i++) begin
            check("t3_drain_idx", 64'(u_wr.wr_btb_idx), 64'(i));
            idle(1'b1);
        end
        check("t3_empty", 64'(q_count), 64'(0));

        // Coalesce onto the tail.
        push_pc(31'h100, 31'h111, 1'b0);
        push_pc(31'h100, 31'h222, 1'b0);
        check("t4_count", 64'(q_count), 64'(1));
        check("t4_tgt", 64'(u_wr.wr_btb_tgt), 64'h222);
        idle(1'b1);

        // Starvation escalation.
        push_pc(31'h40, 31'h7, 1'b0);
        check("t5_req_rise", 64'(u_wr.wr_req), 64'(1));
        first_force = -1;
        for (int k = 1; k <= 20; k++) begin
            idle(1'b0);
            if (first_force < 0 && u_wr.wr_force) first_force = k;
        end
        check("t5_force_delay", 64'(first_force), 64'(LIMIT));
        idle(1'b1);
        check("t5_force_clear", 64'(u_wr.wr_force), 64'(0));

        // Flush together with a grant and a push.
        for (int i = 1; i <= 3; i++) push_pc(31'(i << 2), 31'(i), 1'b0);
        drive_cycle(1'b1, 31'h30, 1'b0, 1'b0, 31'h1, 8'h0, 2'b0, 1'b1, 1'b1, 1'b0);
        check("t6_flush_count", 64'(q_count), 64'(0));
        check("t6_flush_req", 64'(u_wr.wr_req), 64'(0));

        // Reset in the middle of a drain.
        for (int i = 1; i <= 3; i++) push_pc(31'(i << 2), 31'(i), 1'b0);
        idle(1'b1);
        drive_cycle(1'b1, 31'h30, 1'b0, 1'b0, 31'h1, 8'h0, 2'b0, 1'b0, 1'b0, 1'b1);
        check_reset_state("t7_rst");

        // Random traffic over a small PC pool so coalescing occurs.
        for (int i = 0; i < 6; i++) pool_pc[i] = 31'($urandom);
        for (int c = 0; c < 600; c++) begin
            logic [30:0] pc;
            pc = ($urandom_range(0, 4) == 0) ? 31'($urandom) : pool_pc[$urandom_range(0, 5)];
            drive_cycle($urandom_range(0, 9) < 7, pc, 1'($urandom_range(0, 3) == 0),
                        1'($urandom_range(0, 7) == 0), 31'($urandom), 8'($urandom),
                        2'($urandom), $urandom_range(0, 24) == 0,
                        $urandom_range(0, 9) < 4, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
